// File: rtl/load_store_unit.sv
// Load/store sequencer: one byte, halfword or word access on a 32-bit big-endian bus,
// with lane steering, load extension, alignment checking and a bus-ready timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_write,
   input  logic [1:0]  i_cycle_width,
   input  logic        i_signed_load,
   input  logic [31:0] i_address,
   input  logic [31:0] i_write_data,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_access_error,
   output logic [31:0] o_read_data,
   output logic [29:0] o_bus_address,
   output logic        o_bus_request,
   output logic        o_bus_write,
   output logic [3:0]  o_bus_byte_enables,
   output logic [31:0] o_bus_data_out,
   input  logic [31:0] i_bus_data_in,
   input  logic        i_bus_ready
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_FINISH} state_t;

   localparam logic [15:0] LP_LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   logic        r_write;
   logic [1:0]  r_width;
   logic        r_signed;
   logic [1:0]  r_offset;
   logic [15:0] r_count;
   logic        r_busy;
   logic        r_done;
   logic        r_error;
   logic [31:0] r_read_data;
   logic [29:0] r_bus_address;
   logic        r_bus_request;
   logic        r_bus_write;
   logic [3:0]  r_bus_byte_enables;
   logic [31:0] r_bus_data_out;

   function automatic logic f_legal(input logic [1:0] width, input logic [1:0] offset);
      logic ok;
      ok = 1'b0;
      case (width)
         2'b00:   ok = 1'b1;
         2'b01:   ok = (offset[0] == 1'b0);
         2'b10:   ok = (offset == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Big-endian: enable bit 3 is the lowest byte address (bus bits 31:24).
   function automatic logic [3:0] f_byte_enables(input logic [1:0] width, input logic [1:0] offset);
      logic [3:0] be;
      be = 4'b0000;
      case (width)
         2'b00:   be = 4'b1000 >> offset;
         2'b01:   be = offset[1] ? 4'b0011 : 4'b1100;
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] f_steer(input logic [1:0] width, input logic [31:0] data);
      logic [31:0] d;
      d = data;
      case (width)
         2'b00:   d = {4{data[7:0]}};
         2'b01:   d = {2{data[15:0]}};
         default: d = data;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] f_extract(input logic [1:0] width, input logic [1:0] offset,
                                             input logic sgn, input logic [31:0] data);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = data[31:24];
      case (offset)
         2'd0:    b = data[31:24];
         2'd1:    b = data[23:16];
         2'd2:    b = data[15:8];
         default: b = data[7:0];
      endcase
      h = offset[1] ? data[15:0] : data[31:16];
      case (width)
         2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
         2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
         default: r = data;
      endcase
      return r;
   endfunction

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state            <= ST_IDLE;
         r_write            <= 1'b0;
         r_width            <= 2'b00;
         r_signed           <= 1'b0;
         r_offset           <= 2'b00;
         r_count            <= 16'd0;
         r_busy             <= 1'b0;
         r_done             <= 1'b0;
         r_error            <= 1'b0;
         r_read_data        <= 32'd0;
         r_bus_address      <= 30'd0;
         r_bus_request      <= 1'b0;
         r_bus_write        <= 1'b0;
         r_bus_byte_enables <= 4'b0000;
         r_bus_data_out     <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_write  <= i_write;
                  r_width  <= i_cycle_width;
                  r_signed <= i_signed_load;
                  r_offset <= i_address[1:0];
                  r_busy   <= 1'b1;
                  if (f_legal(i_cycle_width, i_address[1:0])) begin
                     r_state            <= ST_ACCESS;
                     r_count            <= 16'd0;
                     r_bus_request      <= 1'b1;
                     r_bus_address      <= i_address[31:2];
                     r_bus_write        <= i_write;
                     r_bus_byte_enables <= f_byte_enables(i_cycle_width, i_address[1:0]);
                     r_bus_data_out     <= f_steer(i_cycle_width, i_write_data);
                  end else begin
                     // Illegal request: report immediately without touching the bus.
                     r_state <= ST_FINISH;
                     r_done  <= 1'b1;
                     r_error <= 1'b1;
                  end
               end
            end
            ST_ACCESS: begin
               if (i_bus_ready) begin
                  r_state       <= ST_FINISH;
                  r_bus_request <= 1'b0;
                  r_done        <= 1'b1;
                  r_error       <= 1'b0;
                  if (!r_write) begin
                     r_read_data <= f_extract(r_width, r_offset, r_signed, i_bus_data_in);
                  end
               end else if (r_count == LP_LAST_COUNT) begin
                  r_state       <= ST_FINISH;
                  r_bus_request <= 1'b0;
                  r_done        <= 1'b1;
                  r_error       <= 1'b1;
               end else begin
                  r_count <= r_count + 16'd1;
               end
            end
            ST_FINISH: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_error <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy             = r_busy;
   assign o_done             = r_done;
   assign o_access_error     = r_error;
   assign o_read_data        = r_read_data;
   assign o_bus_address      = r_bus_address;
   assign o_bus_request      = r_bus_request;
   assign o_bus_write        = r_bus_write;
   assign o_bus_byte_enables = r_bus_byte_enables;
   assign o_bus_data_out     = r_bus_data_out;

endmodule
